itlb_refill_ctrl: RTL and testbench

//  Miss-handling sequencer for the 32-entry ITLB. Accepts one miss at a time and fetches the PTE from the PTW.

---
 rtl/itlb_refill_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_itlb_refill_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itlb_refill_ctrl.sv
// ---------------------------------------------------------------------------
// itlb_refill_ctrl
// Miss-handling sequencer for a 32-entry ITLB. Takes one lookup miss at a
// time, asks the PLRU for a victim, issues a page walk, and writes the
// returned PTE into the victim entry. Owns the per-entry valid vector and
// clears it on sfence.vma (flush_i).
//
// Ports
//   clk_i / rstn_i           clock, synchronous active-low reset
//   miss_vld_i/_vpn_i        miss request in, miss_rdy_o accepts it
//   flush_i                  invalidate all entries, abort any refill
//   ptw_req_vld_o/_vpn_o     page-walk request, ptw_req_rdy_i accepts it
//   ptw_rsp_vld_i/_ppn_i/_attr_i/_fault_i   single-cycle walk response
//   plru_refill_rq_o         PLRU latches its victim index
//   plru_refill_vld_o        victim written, PLRU tree update
//   plru_refill_onehot_i     victim one-hot from the PLRU
//   entry_valid_o            per-entry valid vector
//   wr_en_o/wr_onehot_o/wr_vpn_o/wr_ppn_o/wr_attr_o   entry array write
//   fault_vld_o/fault_vpn_o  one-cycle walk-fault report to fetch
// ---------------------------------------------------------------------------
module itlb_refill_ctrl #(
  parameter int ENTRIES = 32,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 44,
  parameter int ATTR_W  = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               miss_vld_i,
  input  logic [VPN_W-1:0]   miss_vpn_i,
  output logic               miss_rdy_o,
  input  logic               flush_i,
  output logic               ptw_req_vld_o,
  output logic [VPN_W-1:0]   ptw_req_vpn_o,
  input  logic               ptw_req_rdy_i,
  input  logic               ptw_rsp_vld_i,
  input  logic [PPN_W-1:0]   ptw_rsp_ppn_i,
  input  logic [ATTR_W-1:0]  ptw_rsp_attr_i,
  input  logic               ptw_rsp_fault_i,
  output logic               plru_refill_rq_o,
  output logic               plru_refill_vld_o,
  input  logic [ENTRIES-1:0] plru_refill_onehot_i,
  output logic [ENTRIES-1:0] entry_valid_o,
  output logic               wr_en_o,
  output logic [ENTRIES-1:0] wr_onehot_o,
  output logic [VPN_W-1:0]   wr_vpn_o,
  output logic [PPN_W-1:0]   wr_ppn_o,
  output logic [ATTR_W-1:0]  wr_attr_o,
  output logic               fault_vld_o,
  output logic [VPN_W-1:0]   fault_vpn_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VICTIM   = 3'd1,
    S_PTW_REQ  = 3'd2,
    S_PTW_WAIT = 3'd3,
    S_WRITE    = 3'd4,
    S_DRAIN    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ENTRIES-1:0]  entry_valid_q, entry_valid_d;
  logic [ENTRIES-1:0]  victim_q, victim_d;
  logic [VPN_W-1:0]    vpn_q, vpn_d;
  logic [PPN_W-1:0]    ppn_q, ppn_d;
  logic [ATTR_W-1:0]   attr_q, attr_d;
  logic                fault_q, fault_d;
  logic                wr_fire_s;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      entry_valid_q <= '0;
      victim_q      <= '0;
      vpn_q         <= '0;
      ppn_q         <= '0;
      attr_q        <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_valid_q <= entry_valid_d;
      victim_q      <= victim_d;
      vpn_q         <= vpn_d;
      ppn_q         <= ppn_d;
      attr_q        <= attr_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state and datapath capture logic.
  always_comb begin
    state_d       = state_q;
    entry_valid_d = entry_valid_q;
    victim_d      = victim_q;
    vpn_d         = vpn_q;
    ppn_d         = ppn_q;
    attr_d        = attr_q;
    fault_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_vld_i && !flush_i) begin
          vpn_d   = miss_vpn_i;
          state_d = S_VICTIM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VICTIM: begin
        state_d = flush_i ? S_IDLE : S_PTW_REQ;
      end
      S_PTW_REQ: begin
        if (ptw_req_rdy_i) begin
          // The walk is already issued, so a flush here must still absorb
          // its response in DRAIN.
          victim_d = plru_refill_onehot_i;
          state_d  = flush_i ? S_DRAIN : S_PTW_WAIT;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PTW_REQ;
        end
      end
      S_PTW_WAIT: begin
        if (ptw_rsp_vld_i) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else if (ptw_rsp_fault_i) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ppn_d   = ptw_rsp_ppn_i;
            attr_d  = ptw_rsp_attr_i;
            state_d = S_WRITE;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_PTW_WAIT;
        end
      end
      S_WRITE: begin
        entry_valid_d = entry_valid_q | victim_q;
        state_d       = S_IDLE;
      end
      S_DRAIN: begin
        state_d = ptw_rsp_vld_i ? S_IDLE : S_DRAIN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Flush overrides any valid-bit set made above, including in WRITE.
    if (flush_i) begin
      entry_valid_d = '0;
    end else begin
      entry_valid_d = entry_valid_d;
    end
  end

  assign wr_fire_s = (state_q == S_WRITE) && !flush_i;

  // Output decode from current state; data buses are zero when not strobed.
  always_comb begin
    miss_rdy_o        = (state_q == S_IDLE) && !flush_i;
    plru_refill_rq_o  = (state_q == S_VICTIM);
    ptw_req_vld_o     = (state_q == S_PTW_REQ);
    ptw_req_vpn_o     = (state_q == S_PTW_REQ) ? vpn_q : '0;
    wr_en_o           = wr_fire_s;
    plru_refill_vld_o = wr_fire_s;
    entry_valid_o     = entry_valid_q;
    fault_vld_o       = fault_q;
    fault_vpn_o       = fault_q ? vpn_q : '0;
    if (wr_fire_s) begin
      wr_onehot_o = victim_q;
      wr_vpn_o    = vpn_q;
      wr_ppn_o    = ppn_q;
      wr_attr_o   = attr_q;
    end else begin
      wr_onehot_o = '0;
      wr_vpn_o    = '0;
      wr_ppn_o    = '0;
      wr_attr_o   = '0;
    end
  end

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
module tb_itlb_refill_ctrl;

  localparam int MAXC = 8192;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        miss_vld_i;
  logic [26:0] miss_vpn_i;
  logic        miss_rdy_o;
  logic        flush_i;
  logic        ptw_req_vld_o;
  logic [26:0] ptw_req_vpn_o;
  logic        ptw_req_rdy_i;
  logic        ptw_rsp_vld_i;
  logic [43:0] ptw_rsp_ppn_i;
  logic [7:0]  ptw_rsp_attr_i;
  logic        ptw_rsp_fault_i;
  logic        plru_refill_rq_o;
  logic        plru_refill_vld_o;
  logic [31:0] plru_refill_onehot_i;
  logic [31:0] entry_valid_o;
  logic        wr_en_o;
  logic [31:0] wr_onehot_o;
  logic [26:0] wr_vpn_o;
  logic [43:0] wr_ppn_o;
  logic [7:0]  wr_attr_o;
  logic        fault_vld_o;
  logic [26:0] fault_vpn_o;

  itlb_refill_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .miss_vld_i(miss_vld_i), .miss_vpn_i(miss_vpn_i), .miss_rdy_o(miss_rdy_o),
    .flush_i(flush_i),
    .ptw_req_vld_o(ptw_req_vld_o), .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_rdy_i(ptw_req_rdy_i),
    .ptw_rsp_vld_i(ptw_rsp_vld_i), .ptw_rsp_ppn_i(ptw_rsp_ppn_i), .ptw_rsp_attr_i(ptw_rsp_attr_i),
    .ptw_rsp_fault_i(ptw_rsp_fault_i),
    .plru_refill_rq_o(plru_refill_rq_o), .plru_refill_vld_o(plru_refill_vld_o),
    .plru_refill_onehot_i(plru_refill_onehot_i), .entry_valid_o(entry_valid_o),
    .wr_en_o(wr_en_o), .wr_onehot_o(wr_onehot_o), .wr_vpn_o(wr_vpn_o),
    .wr_ppn_o(wr_ppn_o), .wr_attr_o(wr_attr_o),
    .fault_vld_o(fault_vld_o), .fault_vpn_o(fault_vpn_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Expected-output timeline, one slot per cycle, filled by the stimulus
  // from the latency rules (accept T -> rq T+1 -> req from T+2, rsp R -> write R+1).
  bit          exp_rdy   [MAXC];
  bit          exp_rq    [MAXC];
  bit          exp_req   [MAXC];
  logic [26:0] exp_rvpn  [MAXC];
  bit          exp_wr    [MAXC];
  logic [31:0] exp_woh   [MAXC];
  logic [26:0] exp_wvpn  [MAXC];
  logic [43:0] exp_wppn  [MAXC];
  logic [7:0]  exp_wattr [MAXC];
  bit          exp_flt   [MAXC];
  logic [26:0] exp_fvpn  [MAXC];
  logic [31:0] exp_valid [MAXC];

  logic [31:0] model_valid;
  logic [31:0] last_vic;
  int          errs = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // Compare every DUT output against the timeline each cycle.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("miss_rdy", 64'(miss_rdy_o), 64'(exp_rdy[cyc]));
      chk("plru_rq", 64'(plru_refill_rq_o), 64'(exp_rq[cyc]));
      chk("ptw_req_vld", 64'(ptw_req_vld_o), 64'(exp_req[cyc]));
      if (exp_req[cyc]) chk("ptw_req_vpn", 64'(ptw_req_vpn_o), 64'(exp_rvpn[cyc]));
      chk("wr_en", 64'(wr_en_o), 64'(exp_wr[cyc]));
      chk("plru_vld", 64'(plru_refill_vld_o), 64'(exp_wr[cyc]));
      if (exp_wr[cyc]) begin
        chk("wr_onehot", 64'(wr_onehot_o), 64'(exp_woh[cyc]));
        chk("wr_vpn", 64'(wr_vpn_o), 64'(exp_wvpn[cyc]));
        chk("wr_ppn", 64'(wr_ppn_o), 64'(exp_wppn[cyc]));
        chk("wr_attr", 64'(wr_attr_o), 64'(exp_wattr[cyc]));
      end
      chk("fault_vld", 64'(fault_vld_o), 64'(exp_flt[cyc]));
      if (exp_flt[cyc]) chk("fault_vpn", 64'(fault_vpn_o), 64'(exp_fvpn[cyc]));
      chk("entry_valid", 64'(entry_valid_o), 64'(exp_valid[cyc]));
    end
  end

  function automatic logic [26:0] rnd27();
    logic [31:0] r;
    r = $urandom;
    return r[26:0];
  endfunction

  function automatic logic [43:0] rnd44();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    return {a[11:0], b};
  endfunction

  function automatic logic [7:0] rnd8();
    logic [31:0] r;
    r = $urandom;
    return r[7:0];
  endfunction

  // External PLRU stand-in: lowest invalid entry first, otherwise any entry.
  function automatic logic [31:0] pick_victim();
    for (int i = 0; i < 32; i++) if (!model_valid[i]) return 32'h1 << i;
    return 32'h1 << $urandom_range(31, 0);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    miss_vld_i = 1'b0;
    ptw_req_rdy_i = 1'b0;
    ptw_rsp_vld_i = 1'b0;
    ptw_rsp_fault_i = 1'b0;
  endtask

  task automatic flush_now();
    flush_i = 1'b1;
    exp_rdy[cyc] = 1'b0;
    for (int j = cyc + 1; j < MAXC; j++) exp_valid[j] = 32'h0;
    model_valid = 32'h0;
  endtask

  // One miss from acceptance to completion. fl selects where a flush lands:
  // 0 none, 1 VICTIM, 2 PTW_REQ stalled, 3 PTW_REQ handshake, 4 PTW_WAIT idle,
  // 5 PTW_WAIT with response, 6 WRITE. Returns on the first IDLE cycle.
  task automatic do_miss(input logic [26:0] vpn, input int bp, input int dly, input bit flt,
                         input int fl, input logic [43:0] ppn, input logic [7:0] attr);
    int r;
    bit drain;
    logic [31:0] vic;
    drain = 1'b0;
    miss_vld_i = 1'b1;
    miss_vpn_i = vpn;
    step();
    miss_vpn_i = rnd27();
    exp_rq[cyc] = 1'b1;
    exp_rdy[cyc] = 1'b0;
    plru_refill_onehot_i = $urandom;
    if ($urandom_range(3, 0) == 0) begin
      ptw_rsp_vld_i = 1'b1;
      ptw_rsp_fault_i = 1'($urandom_range(1, 0));
    end
    vic = pick_victim();
    last_vic = vic;
    if (fl == 1) begin flush_now(); step(); return; end
    step();
    plru_refill_onehot_i = vic;
    for (int i = 0; i < bp; i++) begin
      exp_req[cyc] = 1'b1;
      exp_rvpn[cyc] = vpn;
      exp_rdy[cyc] = 1'b0;
      if (fl == 2) begin flush_now(); step(); return; end
      step();
    end
    exp_req[cyc] = 1'b1;
    exp_rvpn[cyc] = vpn;
    exp_rdy[cyc] = 1'b0;
    ptw_req_rdy_i = 1'b1;
    if (fl == 3) begin flush_now(); drain = 1'b1; end
    step();
    plru_refill_onehot_i = $urandom;
    for (int i = 0; i < dly; i++) begin
      exp_rdy[cyc] = 1'b0;
      if (fl == 4 && i == 0) begin flush_now(); drain = 1'b1; end
      step();
    end
    r = cyc;
    exp_rdy[r] = 1'b0;
    ptw_rsp_vld_i = 1'b1;
    ptw_rsp_ppn_i = ppn;
    ptw_rsp_attr_i = attr;
    ptw_rsp_fault_i = flt;
    if (fl == 5) flush_now();
    step();
    ptw_rsp_ppn_i = rnd44();
    if (drain || fl == 5) return;
    if (flt) begin
      exp_flt[r + 1] = 1'b1;
      exp_fvpn[r + 1] = vpn;
      return;
    end
    exp_rdy[r + 1] = 1'b0;
    if (fl == 6) begin
      flush_now();
    end else begin
      exp_wr[r + 1] = 1'b1;
      exp_woh[r + 1] = vic;
      exp_wvpn[r + 1] = vpn;
      exp_wppn[r + 1] = ppn;
      exp_wattr[r + 1] = attr;
      model_valid = model_valid | vic;
      for (int j = r + 2; j < MAXC; j++) exp_valid[j] = exp_valid[j] | vic;
    end
    step();
  endtask

  task automatic idle_cycle(input bit do_fl, input bit spur);
    if (spur) begin
      ptw_rsp_vld_i = 1'b1;
      ptw_rsp_fault_i = 1'($urandom_range(1, 0));
    end
    if (do_fl) begin
      miss_vld_i = 1'b1;
      miss_vpn_i = rnd27();
      flush_now();
    end
    step();
  endtask

  initial begin
    int bp, dly, fl;
    for (int j = 0; j < MAXC; j++) begin
      exp_rdy[j] = 1'b1; exp_rq[j] = 1'b0; exp_req[j] = 1'b0; exp_rvpn[j] = 27'h0;
      exp_wr[j] = 1'b0; exp_woh[j] = 32'h0; exp_wvpn[j] = 27'h0; exp_wppn[j] = 44'h0;
      exp_wattr[j] = 8'h0; exp_flt[j] = 1'b0; exp_fvpn[j] = 27'h0; exp_valid[j] = 32'h0;
    end
    model_valid = 32'h0;
    last_vic = 32'h0;
    rstn_i = 1'b0; miss_vld_i = 1'b0; miss_vpn_i = 27'h0; flush_i = 1'b0;
    ptw_req_rdy_i = 1'b0; ptw_rsp_vld_i = 1'b0; ptw_rsp_ppn_i = 44'h0;
    ptw_rsp_attr_i = 8'h0; ptw_rsp_fault_i = 1'b0; plru_refill_onehot_i = 32'h0;
    step();
    chk_en = 1'b1;
    step();
    step();
    rstn_i = 1'b1;
    chk("reset_valid", 64'(entry_valid_o), 64'h0);
    chk("reset_rdy", 64'(miss_rdy_o), 64'h1);

    // Cold fill: first two victims are entries 0 and 1.
    do_miss(27'h1, 0, 3, 1'b0, 0, 44'h80, 8'hCF);
    chk("cold_vic0", 64'(last_vic), 64'h1);
    chk("cold_valid0", 64'(entry_valid_o), 64'h1);
    do_miss(27'h2, 0, 1, 1'b0, 0, 44'h81, 8'hCF);
    chk("cold_vic1", 64'(last_vic), 64'h2);
    chk("cold_valid1", 64'(entry_valid_o), 64'h3);

    // Fill the rest, then a replacement miss leaves valid unchanged.
    for (int i = 2; i < 32; i++)
      do_miss(rnd27(), $urandom_range(2, 0), $urandom_range(3, 0), 1'b0, 0, rnd44(), rnd8());
    chk("full_valid", 64'(entry_valid_o), 64'hFFFF_FFFF);
    do_miss(rnd27(), 1, 2, 1'b0, 0, rnd44(), rnd8());
    chk("replace_valid", 64'(entry_valid_o), 64'hFFFF_FFFF);

    // Fault report, then backpressure of five cycles.
    do_miss(27'h55, 0, 2, 1'b1, 0, 44'h0, 8'h0);
    idle_cycle(1'b0, 1'b0);
    chk("fault_valid", 64'(entry_valid_o), 64'hFFFF_FFFF);
    do_miss(rnd27(), 5, 1, 1'b0, 0, rnd44(), rnd8());

    // Flush while waiting for the walk; late ppn 0x9 must be dropped.
    do_miss(27'h66, 0, 3, 1'b0, 4, 44'h9, 8'hCF);
    chk("flush_wait_valid", 64'(entry_valid_o), 64'h0);

    // Flush colliding with the write.
    do_miss(rnd27(), 0, 1, 1'b0, 0, rnd44(), rnd8());
    do_miss(rnd27(), 0, 1, 1'b0, 6, rnd44(), rnd8());
    chk("flush_write_valid", 64'(entry_valid_o), 64'h0);

    // Reset while in PTW_WAIT; the late response is ignored.
    do_miss(rnd27(), 0, 0, 1'b0, 0, rnd44(), rnd8());
    miss_vld_i = 1'b1;
    miss_vpn_i = 27'h77;
    step();
    exp_rq[cyc] = 1'b1; exp_rdy[cyc] = 1'b0;
    step();
    plru_refill_onehot_i = 32'h4;
    ptw_req_rdy_i = 1'b1;
    exp_req[cyc] = 1'b1; exp_rvpn[cyc] = 27'h77; exp_rdy[cyc] = 1'b0;
    step();
    exp_rdy[cyc] = 1'b0;
    rstn_i = 1'b0;
    for (int j = cyc + 1; j < MAXC; j++) exp_valid[j] = 32'h0;
    model_valid = 32'h0;
    step();
    rstn_i = 1'b1;
    ptw_rsp_vld_i = 1'b1;
    ptw_rsp_ppn_i = 44'h123;
    step();
    step();
    chk("reset_mid_valid", 64'(entry_valid_o), 64'h0);

    // Randomised mix of misses, flush positions, gaps and stray responses.
    for (int n = 0; n < 150 && cyc < MAXC - 200; n++) begin
      for (int g = $urandom_range(3, 0); g > 0; g--)
        idle_cycle($urandom_range(15, 0) == 0, $urandom_range(3, 0) == 0);
      bp  = $urandom_range(3, 0);
      dly = $urandom_range(4, 0);
      fl  = ($urandom_range(9, 0) < 5) ? 0 : int'($urandom_range(6, 1));
      if (fl == 2 && bp == 0) bp = 1;
      if (fl == 4 && dly == 0) dly = 1;
      do_miss(rnd27(), bp, dly, $urandom_range(4, 0) == 0, fl, rnd44(), rnd8());
    end
    step();
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
